// File: rtl/dec_pkg.sv
// dec_pkg: shared types, sizes and the one-hot helper for the sequential 3-to-8 decoder
//   DEC_W   : binary code width
//   DEC_N   : number of one-hot output lines
//   state_t : decoder FSM states (SCAN is only entered when DEC_SCAN_EN is defined)
//   onehot  : code -> one-hot word
package dec_pkg;
    localparam int DEC_W = 3;
    localparam int DEC_N = 8;
    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
    function automatic logic [DEC_N-1:0] onehot(input logic [DEC_W-1:0] code);
        return DEC_N'(1) << code;
    endfunction
endpackage

// File: rtl/decoder_3_to_8_seq_hold_counter.sv
// hold_counter: loadable down-counter that times how long each one-hot word stays on the outputs
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to zero (abort)
//   load     : load load_val (takes priority over dec)
//   load_val : value loaded at the start of a hold window
//   dec      : decrement, saturating at zero
//   zero     : count is zero (hold window ends this cycle)
module hold_counter
    import dec_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign zero = cnt_q == '0;
    always_comb
        cnt_d = clr ? '0 : load ? load_val : (dec && !zero) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/decoder_3_to_8_seq.sv
// decoder_3_to_8_seq: registered 3-to-8 decoder with valid/ready intake and a programmable hold time
//   clk, rst   : clock, synchronous active-high reset
//   en         : block enable; dropping it aborts the current word without a done pulse
//   in_valid   : code presented;   in_ready : code accepted this cycle (IDLE & en & ~rst)
//   code       : binary code to decode
//   scan_start : start a 0..7 sweep (used only when DEC_SCAN_EN is defined)
//   out        : registered one-hot word, held HOLD_CYCLES cycles
//   out_valid  : out holds a decoded word
//   busy       : FSM not idle
//   done       : one-cycle pulse after a word (or a full sweep) completes normally
// Optional feature macro: DEC_SCAN_EN adds the SCAN state and its index register.
module decoder_3_to_8_seq
    import dec_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DEC_W-1:0] code,
    input  logic             scan_start,
    output logic [DEC_N-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [DEC_N-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic             cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic             scan_go, accept;

`ifdef DEC_SCAN_EN
    logic [DEC_W-1:0] idx_q, idx_d;
    assign scan_go = scan_start & in_ready;
`else
    logic unused_scan_start;
    assign unused_scan_start = scan_start;
    assign scan_go = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE) & en & ~rst;
    // a sweep request wins over a simultaneous code, which is then not consumed
    assign accept    = in_valid & in_ready & ~scan_go;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = state_q != IDLE;

    hold_counter #(.CNT_W(CNT_W)) u_hold_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .load    (cnt_load),
        .load_val(LOAD_VAL),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        cnt_clr     = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
`ifdef DEC_SCAN_EN
        idx_d       = idx_q;
`endif
        if (!en) begin
            state_d     = IDLE;
            out_d       = '0;
            out_valid_d = 1'b0;
            cnt_clr     = 1'b1;
`ifdef DEC_SCAN_EN
            idx_d       = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan_go) begin
                        state_d     = SCAN;
                        out_d       = onehot('0);
                        out_valid_d = 1'b1;
                        cnt_load    = 1'b1;
`ifdef DEC_SCAN_EN
                        idx_d       = '0;
`endif
                    end else if (accept) begin
                        state_d     = HOLD;
                        out_d       = onehot(code);
                        out_valid_d = 1'b1;
                        cnt_load    = 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        state_d     = IDLE;
                        out_d       = '0;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
`ifdef DEC_SCAN_EN
                SCAN: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else if (idx_q == DEC_W'(DEC_N - 1)) begin
                        state_d     = IDLE;
                        out_d       = '0;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        idx_d       = '0;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        out_d    = onehot(idx_q + 1'b1);
                        cnt_load = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d     = IDLE;
                    out_d       = '0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef DEC_SCAN_EN
            idx_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef DEC_SCAN_EN
            idx_q       <= idx_d;
`endif
        end
    end
endmodule
